// File: rtl/mac_pkg.sv
// mac_pkg: shared state enum, default sizes and datapath types for the MAC sequencer
package mac_pkg;
  localparam int DW      = 16;
  localparam int ACC_W   = 40;
  localparam int CNT_W   = 8;
  localparam int MUL_LAT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef logic [2*DW-1:0]  prod_t;
  typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/mac_vld_pipe.sv
// mac_vld_pipe: in-flight valid shift register tracking issued multiplier operations
module mac_vld_pipe #(
  parameter int LAT = mac_pkg::MUL_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  output logic tail_o,
  output logic empty_o
);
  logic [LAT-1:0] pipe_q, pipe_d;
  // shift new issues in at the head; tail marks a product present on mul_p this cycle,
  // empty means nothing remains in flight after this cycle
  always_comb begin
    pipe_d  = LAT'({pipe_q, vld_i});
    tail_o  = pipe_q[LAT-1];
    empty_o = pipe_d == '0;
  end
  // in-flight register; reset discards anything outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: operand sequencer and dot-product accumulator for the pipelined multiplier
// Define MAC_SAT_EN to clamp the accumulator to all-ones on overflow instead of wrapping.
module mac_seq_ctrl #(
  parameter int DW      = mac_pkg::DW,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int CNT_W   = mac_pkg::CNT_W,
  parameter int MUL_LAT = mac_pkg::MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_a,
  input  logic [DW-1:0]     in_b,
  output logic [DW-1:0]     mul_a,
  output logic [DW-1:0]     mul_b,
  output logic              mul_vld,
  input  logic [2*DW-1:0]   mul_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              ovf
);
  import mac_pkg::*;
  state_e state_q, state_d;
  logic [CNT_W-1:0] len_q, iss_q, iss_d, ret_q, ret_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic [DW-1:0]    mul_a_q, mul_b_q;
  logic ovf_q, ovf_d, mul_vld_q, accept, start_ok, tail, empty;

  mac_vld_pipe #(.LAT(MUL_LAT)) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (mul_vld_q),
    .tail_o (tail),
    .empty_o(empty)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; DRAIN exits on the cycle the final product is absorbed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (len == '0 ? DONE : RUN) : IDLE;
      RUN:     state_d = iss_d == len_q ? DRAIN : RUN;
      DRAIN:   state_d = ret_d == len_q && empty ? DONE : DRAIN;
      DONE:    state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // handshake, status and result outputs
  always_comb begin
    busy      = state_q != IDLE;
    in_ready  = state_q == RUN && iss_q < len_q;
    res_valid = state_q == DONE;
    accept    = in_valid && in_ready;
    start_ok  = state_q == IDLE && start;
    mul_vld   = mul_vld_q;
    mul_a     = mul_a_q;
    mul_b     = mul_b_q;
    res_data  = acc_q;
    ovf       = ovf_q;
  end

  // counter advance and accumulation of the returned, zero-extended product
  always_comb begin
    iss_d = iss_q + CNT_W'(accept);
    ret_d = ret_q + CNT_W'(tail);
    sum   = {1'b0, acc_q} + (ACC_W+1)'(mul_p);
`ifdef MAC_SAT_EN
    acc_d = tail ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : acc_q;
`else
    acc_d = tail ? sum[ACC_W-1:0] : acc_q;
`endif
    ovf_d = ovf_q | (tail & sum[ACC_W]);
  end

  // issue registers, counters and accumulator; start clears the job context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      len_q     <= '0;
      iss_q     <= '0;
      ret_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mul_vld_q <= accept;
      mul_a_q   <= accept ? in_a : mul_a_q;
      mul_b_q   <= accept ? in_b : mul_b_q;
      len_q     <= start_ok ? len : len_q;
      iss_q     <= start_ok ? '0 : iss_d;
      ret_q     <= start_ok ? '0 : ret_d;
      acc_q     <= start_ok ? '0 : acc_d;
      ovf_q     <= ~start_ok & ovf_d;
    end
  end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: randomized and directed checks of mac_seq_ctrl against a job-level model
module tb_mac_seq_ctrl;
  localparam int L = 1;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [7:0]  len = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic [31:0] mul_p = 0;
  logic busy, in_ready, mul_vld, res_valid, ovf;
  logic busy2, in_ready2, mul_vld2, res_valid2, ovf2;
  logic [15:0] mul_a, mul_b, mul_a2, mul_b2;
  logic [39:0] res_data;
  logic [31:0] res2;

  mac_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .ovf(ovf)
  );

  mac_seq_ctrl #(.ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_vld(mul_vld2), .mul_p(mul_p),
    .res_valid(res_valid2), .res_ready(res_ready), .res_data(res2), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0, n_vld = 0, n_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] fold(input logic [63:0] s, input int w, output bit o);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    o = s > lim;
`ifdef MAC_SAT_EN
    return o ? lim : s;
`else
    return s & lim;
`endif
  endfunction

  // job-level model: exact dot product, folded to each accumulator width at completion
  bit m_act = 0, m_done = 0, m_vld = 0, o40 = 0, o32 = 0;
  bit r, rdy, acc_now, st_now, hs_now;
  int m_iss = 0, m_due = -1;
  logic [7:0]  m_len = 0;
  logic [15:0] m_a = 0, m_b = 0;
  logic [63:0] m_sum = 0, e40 = 0, e32 = 0;
  logic [31:0] pmap [int];

  always @(negedge clk) begin
    r   = rst_n;
    rdy = r && m_act && !m_done && m_iss < int'(m_len);
    chk("busy",      64'(busy),      64'(r && m_act));
    chk("in_ready",  64'(in_ready),  64'(rdy));
    chk("mul_vld",   64'(mul_vld),   64'(r && m_vld));
    chk("res_valid", 64'(res_valid), 64'(r && m_done));
    chk("mul_ab",    64'({mul_a, mul_b}), r ? 64'({m_a, m_b}) : 64'd0);
    chk("ctl32", 64'({busy2, in_ready2, mul_vld2, res_valid2}),
        64'({r && m_act, rdy, r && m_vld, r && m_done}));
    if (!r || !m_act || m_done) begin
      chk("res_data", 64'(res_data), r ? e40 : 64'd0);
      chk("ovf",      64'(ovf),      64'(r && o40));
      chk("res32",    64'(res2),     r ? e32 : 64'd0);
      chk("ovf32",    64'(ovf2),     64'(r && o32));
    end
    if (r && mul_vld) n_vld++;
    if (r && in_ready) n_rdy++;
    mul_p = pmap.exists(cyc) ? pmap[cyc] : $urandom;
    if (!r) begin
      m_act = 0; m_done = 0; m_vld = 0; m_a = 0; m_b = 0; m_iss = 0; m_len = 0;
      m_sum = 0; e40 = 0; e32 = 0; o40 = 0; o32 = 0; m_due = -1;
      pmap.delete();
    end else begin
      acc_now = rdy && in_valid;
      st_now  = !m_act && start;
      hs_now  = m_done && res_ready;
      m_vld   = acc_now;
      if (acc_now) begin
        m_a = in_a;
        m_b = in_b;
        pmap[cyc+1+L] = {16'd0, in_a} * {16'd0, in_b};
        m_sum += 64'(in_a) * 64'(in_b);
        m_iss++;
        if (m_iss == int'(m_len)) m_due = cyc + 2 + L;
      end
      if (st_now) begin
        m_act = 1; m_len = len; m_iss = 0; m_sum = 0;
        m_due = (len == 0) ? cyc + 1 : -1;
      end
      if (hs_now) begin
        m_act = 0;
        m_done = 0;
      end
      if (m_act && !m_done && m_due == cyc + 1) begin
        m_done = 1;
        e40 = fold(m_sum, 40, o40);
        e32 = fold(m_sum, 32, o32);
      end
    end
    cyc++;
  end

  logic [15:0] ja [256], jb [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 back-to-back, k>0 one valid then k idle cycles, <0 random valid
  task automatic run_job(input int n, input int gap, input int hold, input bit poke,
                         output int st, output int ac, output int rv);
    int i, w, c;
    n_vld = 0; n_rdy = 0; ac = -1; rv = -1;
    st = cyc; start = 1; len = 8'(n);
    tick();
    start = 0; i = 0; w = 0;
    while (i < n && w < 2000) begin
      in_valid = gap < 0 ? 1'($urandom) : (w % (gap + 1) == 0);
      in_a = in_valid ? ja[i] : 16'($urandom);
      in_b = in_valid ? jb[i] : 16'($urandom);
      c = cyc;
      @(negedge clk);
      if (in_valid && in_ready) begin
        ac = c;
        i++;
      end
      tick();
      w++;
    end
    chk("accepts", 64'(i), 64'(n));
    w = 0;
    while (w < 2000) begin
      in_valid = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      c = cyc;
      @(negedge clk);
      if (res_valid) begin
        rv = c;
        break;
      end
      tick();
      w++;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    tick();
    in_valid = 0;
    for (int h = 0; h < hold; h++) begin
      res_ready = 0;
      start = poke && h == 1;
      len = 8'($urandom);
      tick();
    end
    start = 0; res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int st, ac, rv, n;
    bit big;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
    for (int i = 0; i < 4; i++) begin ja[i] = 16'(i + 1); jb[i] = 16'd1; end
    run_job(4, 0, 0, 0, st, ac, rv);
    chk("t1_res", 64'(res_data), 64'd10);
    chk("t1_ovf", 64'(ovf), 64'd0);
    chk("t1_lat", 64'(rv - ac), 64'd3);
    for (int i = 0; i < 3; i++) begin ja[i] = 16'hFFFF; jb[i] = 16'hFFFF; end
    run_job(3, 2, 1, 0, st, ac, rv);
    chk("t2_res", 64'(res_data), 64'h2_FFFA_0003);
    chk("t2_pulses", 64'(n_vld), 64'd3);
    run_job(0, 0, 0, 0, st, ac, rv);
    chk("t3_lat", 64'(rv - st), 64'd1);
    chk("t3_res", 64'(res_data), 64'd0);
    chk("t3_pulses", 64'(n_vld), 64'd0);
    chk("t3_rdy", 64'(n_rdy), 64'd0);
    run_job(2, 0, 1, 0, st, ac, rv);
    chk("t4_ovf32", 64'(ovf2), 64'd1);
`ifdef MAC_SAT_EN
    chk("t4_res32", 64'(res2), 64'hFFFF_FFFF);
`else
    chk("t4_res32", 64'(res2), 64'hFFFC_0002);
`endif
    chk("t4_res40", 64'(res_data), 64'h1_FFFC_0002);
    chk("t4_ovf40", 64'(ovf), 64'd0);
    ja[0] = 16'd100; jb[0] = 16'd7;
    run_job(1, 0, 4, 1, st, ac, rv);
    chk("t5_idle", 64'({busy, res_valid}), 64'd0);
    chk("t5_res", 64'(res_data), 64'd700);
    start = 1; len = 8'd4;
    tick();
    start = 0; in_valid = 1; in_a = 16'd7; in_b = 16'd9;
    tick();
    in_a = 16'd8;
    tick();
    in_valid = 0; rst_n = 0;
    #1;
    chk("rst_ctl", 64'({busy, in_ready, mul_vld, res_valid, ovf}), 64'd0);
    chk("rst_mul", 64'({mul_a, mul_b}), 64'd0);
    chk("rst_res", 64'(res_data), 64'd0);
    tick();
    rst_n = 1;
    tick();
    ja[0] = 16'd3; jb[0] = 16'd5;
    run_job(1, 0, 0, 0, st, ac, rv);
    chk("t6_res", 64'(res_data), 64'd15);
    for (int j = 0; j < 30; j++) begin
      n = (j == 7) ? 255 : int'($urandom_range(12, 0));
      big = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        ja[i] = big ? 16'($urandom_range(16'hFFFF, 16'hF000)) : 16'($urandom);
        jb[i] = big ? 16'($urandom_range(16'hFFFF, 16'hF000)) : 16'($urandom);
      end
      run_job(n, (j % 3 == 0) ? 0 : -1, int'($urandom_range(3, 0)), j % 4 == 1, st, ac, rv);
      in_valid = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      tick();
      in_valid = 0;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the pipelined 16x16 unsigned multiplier built from the 2x2 multiplier cells.
- Accepts a stream of operand pairs on a valid/ready interface and issues each pair to the multiplier.
- Tracks in-flight products and accumulates the returned products into a wide accumulator.
- After a programmed number of pairs, presents one dot-product result on a valid/ready output.

Parameters:
- DW, 16, operand width; the multiplier product is 2*DW.
- ACC_W, 40, accumulator and result width; must be at least 2*DW.
- CNT_W, 8, width of the pair-count field len.
- MUL_LAT, 1, fixed multiplier latency in cycles, from the mul_vld cycle to the mul_p-valid cycle; must be at least 1.

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
- len  input  CNT_W  number of operand pairs in the job; captured on start.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept a pair.
- in_a  input  DW  operand A (unsigned).
- in_b  input  DW  operand B (unsigned).
- mul_a  output  DW  registered operand to the multiplier.
- mul_b  output  DW  registered operand to the multiplier.
- mul_vld  output  1  the issued pair is valid this cycle.
- mul_p  input  2*DW  multiplier product, valid MUL_LAT cycles after the matching mul_vld cycle.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  ACC_W  accumulated dot product.
- ovf  output  1  accumulator overflow seen during the current job.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, mul_vld, mul_a, mul_b, res_valid, res_data, ovf, busy.
  - The in-flight tracker, issue counter, return counter and accumulator are cleared.
  - Products in flight at reset are discarded and never accumulated.
- IDLE:
  - in_ready=0.
  - start=1 captures len, clears the accumulator, ovf and both counters.
  - If len=0, go to DONE with res_data=0; otherwise go to RUN.
- RUN:
  - in_ready=1 while the issue count is less than len.
  - An acceptance (in_valid & in_ready) at cycle t registers in_a/in_b into mul_a/mul_b, drives mul_vld=1 in cycle t+1, and increments the issue count.
  - mul_vld=0 in any cycle with no acceptance in the prior cycle; mul_a/mul_b hold their last values.
  - When the issue count reaches len, in_ready drops in the same cycle and the state goes to DRAIN.
- In-flight tracking:
  - An MUL_LAT-deep valid shift register is fed by mul_vld.
  - When its tail is set, mul_p is added to the accumulator at the end of that cycle and the return count increments.
  - Accumulation happens in RUN and DRAIN alike.
- DRAIN:
  - Leave when the return count equals len and the tracker is empty; go to DONE.
  - For the last acceptance at cycle t, res_valid rises in cycle t+2+MUL_LAT.
- DONE:
  - res_valid=1; res_data and ovf are held stable until res_ready=1.
  - The handshake cycle returns the state to IDLE, with res_valid=0 the next cycle.
  - res_data keeps its value after the handshake; ovf is cleared only on the next start.
- Arithmetic:
  - The product is zero-extended to ACC_W before the add.
  - A carry out of the accumulator sets ovf, which is sticky for the job.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid outside RUN is ignored.
  - A simultaneous acceptance and product return in one cycle are both handled.
  - len at its maximum value (2^CNT_W-1) is legal.
  - The controller never backpressures the multiplier.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined: on overflow the accumulator clamps to all-ones, stays clamped for the rest of the job, and ovf=1.
- Undefined: the accumulator wraps modulo 2^ACC_W and ovf=1 still flags the wrap.
- Ports are identical in both builds.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default constants DW, ACC_W, CNT_W, MUL_LAT;
  - the product and accumulator width typedefs.
- One sub-module, mac_vld_pipe: the MUL_LAT-deep in-flight valid shift register, with an empty flag and a tail output.

Test Plan:
- MUL_LAT=1, len=4, pairs (1,1) (2,1) (3,1) (4,1) streamed back-to-back -> res_data=10, ovf=0, res_valid 3 cycles after the last acceptance.
- len=3, in_valid gapped (1 on, 2 off), pairs (0xFFFF,0xFFFF) x3 -> res_data=3*0xFFFE0001=0x2FFFA0003, mul_vld pulses exactly 3.
- start with len=0 -> DONE next cycle, res_data=0, no mul_vld pulse, in_ready never high.
- ACC_W=32, len=2, pairs (0xFFFF,0xFFFF) x2 -> ovf=1; res_data=0xFFFC0002 without MAC_SAT_EN, 0xFFFFFFFF with it.
- res_ready held low 5 cycles in DONE, with start pulsed during that time -> res_data stable, start ignored, IDLE only after the handshake.
- rst_n pulsed low mid-RUN after 2 of 4 pairs -> all outputs 0 immediately; a new job with len=1, pair (3,5) -> res_data=15.
